// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off strobes onto NUM_VOICES voices,
// retriggering held notes, filling free voices lowest-first, and stealing
// round-robin when every voice is sounding.

// One voice: note/gate/trig registers driven by one-hot commands from the top.
module voice_alloc_lane #(
  parameter int NOTE_W = 8
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              ld_i,    // load new note, open gate, pulse trig
  input  logic              rt_i,    // retrigger only
  input  logic              clr_i,   // close gate, keep note for release
  input  logic [NOTE_W-1:0] note_i,
  output logic [NOTE_W-1:0] note_o,
  output logic              gate_o,
  output logic              trig_o
);
  logic [NOTE_W-1:0] note_q, note_d;
  logic              gate_q, gate_d, trig_q, trig_d;

  // Next state: trig is a pure pulse, load wins over clear (never both).
  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    trig_d = ld_i | rt_i;
    if (ld_i) begin
      note_d = note_i;
      gate_d = 1'b1;
    end else if (clr_i) begin
      gate_d = 1'b0;
    end
  end

  // Voice registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      note_q <= '0;
      gate_q <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      note_q <= note_d;
      gate_q <= gate_d;
      trig_q <= trig_d;
    end
  end

  assign note_o = note_q;
  assign gate_o = gate_q;
  assign trig_o = trig_q;
endmodule

module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         nrst_i,
  input  logic [NOTE_W-1:0]            note_i,
  input  logic                         noteOnStrb_i,
  input  logic                         noteOffStrb_i,
  input  logic                         allOff_i,
  output logic [NUM_VOICES*NOTE_W-1:0] voiceNote_o,
  output logic [NUM_VOICES-1:0]        voiceGate_o,
  output logic [NUM_VOICES-1:0]        voiceTrig_o,
  output logic                         steal_o
);
  localparam int PW = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0] match, free_v, free_oh, ld, rt, clr;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  steal_q, steal_d;

  // A match needs an open gate: stale notes in released voices never match.
  always_comb begin
    for (int k = 0; k < NUM_VOICES; k++)
      match[k] = voiceGate_o[k] && (voiceNote_o[k*NOTE_W +: NOTE_W] == note_i);
  end

  assign free_v  = ~voiceGate_o;
  assign free_oh = free_v & (~free_v + NUM_VOICES'(1));  // lowest free voice

  // Request decode: allOff > noteOff > noteOn, one request per cycle.
  always_comb begin
    ld      = '0;
    rt      = '0;
    clr     = '0;
    steal_d = 1'b0;
    ptr_d   = ptr_q;
    if (allOff_i) begin
      clr = '1;
    end else if (noteOffStrb_i) begin
      clr = match;
    end else if (noteOnStrb_i) begin
      if (|match) begin
        rt = match;
      end else if (|free_v) begin
        ld = free_oh;
      end else begin
        ld      = NUM_VOICES'(1) << ptr_q;
        steal_d = 1'b1;
        ptr_d   = (ptr_q == PW'(NUM_VOICES - 1)) ? '0 : ptr_q + PW'(1);
      end
    end
  end

  // Steal pointer and steal pulse.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ptr_q   <= '0;
      steal_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      steal_q <= steal_d;
    end
  end

  assign steal_o = steal_q;

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_lane
    voice_alloc_lane #(.NOTE_W(NOTE_W)) u_lane (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .ld_i   (ld[k]),
      .rt_i   (rt[k]),
      .clr_i  (clr[k]),
      .note_i (note_i),
      .note_o (voiceNote_o[k*NOTE_W +: NOTE_W]),
      .gate_o (voiceGate_o[k]),
      .trig_o (voiceTrig_o[k])
    );
  end
endmodule
